program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream feeder of the instruction BRAM.
- Receives the program as a byte stream from the UART receiver and assembles 4 bytes into one 32-bit instruction word.
- Drives the BRAM write port, one word per address, starting at address 0.
- Stops on a halt word, or on memory exhaustion. Releases the pipeline (o_done) only after the full program is written.

Parameters:
- ADDRESS_BITS, 8, BRAM word-address width; memory depth is 2**ADDRESS_BITS.
- DATA_BITS, 32, instruction word width; must be 4*8. Other values are unsupported.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker. It is itself written to memory.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  1-cycle pulse: begin a load session. Honoured only in IDLE, DONE or ERROR.
- i_rx_data  in  8  byte from UART receiver.
- i_rx_valid  in  1  1-cycle strobe: i_rx_data valid this cycle.
- o_write_enable  out  1  BRAM write strobe.
- o_address  out  ADDRESS_BITS  BRAM address.
- o_data  out  DATA_BITS  BRAM write data.
- o_busy  out  1  high in RECV and WRITE.
- o_done  out  1  high in DONE (halt word written).
- o_error  out  1  high in ERROR (memory full without halt).
- o_word_count  out  ADDRESS_BITS+1  words written this session.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- All outputs are registered. Reset forces state=IDLE and clears every output to 0: o_write_enable, o_address, o_data, o_busy, o_done, o_error, o_word_count. Byte counter is cleared to 0.
- Byte order: big-endian. The first byte lands in [31:24], the 4th byte in [7:0]. Shift register: word <= {word[23:0], i_rx_data}.
- IDLE: i_rx_valid is ignored. i_start -> RECV, with address=0, byte_cnt=0, word_count=0.
- RECV: each i_rx_valid shifts one byte in and increments byte_cnt (2 bits).
  - On the 4th byte (byte_cnt==3), o_data is loaded with the completed word next cycle and the FSM goes to WRITE.
- WRITE: lasts exactly 1 cycle. o_write_enable=1 with stable o_address and o_data. word_count increments. Next state:
  - word==HALT_WORD -> DONE.
  - else address==2**ADDRESS_BITS-1 -> ERROR.
  - else address+1 -> RECV.
- Latency: 4th-byte strobe at cycle N -> o_write_enable high at cycle N+1 -> back in RECV at N+2. The BRAM commits on the same posedge that ends the WRITE cycle.
- i_rx_valid during WRITE is dropped. The UART byte period is at least 10 clk, so this cannot occur in system. The bench checks that it is dropped and that byte_cnt is unaffected.
- o_write_enable is never high outside WRITE and never high for 2 consecutive cycles.
- DONE and ERROR are sticky. o_address and o_word_count hold their final values. i_rx_valid is ignored. i_start restarts the session (clears counters, flags and address, then enters RECV).
- i_start in RECV or WRITE is ignored. No restart mid-word.
- rst mid-session (any state) returns the block to IDLE with everything cleared, including any partial word. Memory contents already written are not cleared.
- Address wrap: o_address never wraps. The last address is written, then the FSM goes to ERROR, unless that word is HALT_WORD, in which case DONE has priority.
- o_word_count range: 0..2**ADDRESS_BITS, hence the extra bit.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=3'd0, RECV=3'd1, WRITE=3'd2, DONE=3'd3, ERROR=3'd4.
  - HALT_WORD default.
  - ADDRESS_BITS / DATA_BITS defaults, the same values the BRAM uses.
- One sub-module is natural: byte_packer. It takes the 8-bit strobe in and produces the 32-bit word plus a 1-cycle word_valid out, with clear input. The FSM and address counter stay in program_loader.

Test Plan:
- Reset mid-word: rst held 2 cycles after 2 bytes -> all outputs 0, state IDLE. Then i_start and bytes 11 22 33 44 -> write at addr 0 of 32'h11223344, with no stale bytes.
- Basic load: i_start, then bytes 20 01 00 05, 00 00 00 00, FF FF FF FF.
  - 3 writes: addr0=32'h20010005, addr1=32'h00000000, addr2=32'hFFFFFFFF.
  - o_done=1, o_word_count=3, o_address=2.
- Write timing: 4th byte strobe at cycle N -> o_write_enable=1 only at N+1, o_data stable. A spurious i_rx_valid at N+1 is dropped; the next word still assembles from the following 4 bytes.
- Overflow: ADDRESS_BITS=2, 16 non-halt bytes -> 4 writes at addr 0..3, then o_error=1, o_done=0, o_word_count=4, o_address=3.
  - Same setup with word 4 = FFFFFFFF -> o_done=1, o_error=0.
- Restart/ignore: in DONE, stray bytes cause no write. i_start pulses during RECV are ignored. i_start in DONE clears o_done and o_word_count, and the next word is written to addr 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and default sizes for the program loader
package program_loader_pkg;

  localparam int          ADDRESS_BITS_DEFAULT = 8;
  localparam int          DATA_BITS_DEFAULT    = 32;
  localparam logic [31:0] HALT_WORD_DEFAULT    = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD       = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// rtl/program_loader_byte_packer.sv - big-endian byte-to-word assembler with clear
module program_loader_byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  // Only the first three bytes are stored; the fourth completes the word on the fly.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;

  assign o_word       = {shift_q, i_byte};
  assign o_word_valid = i_byte_valid && !i_clear && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    if (i_clear) begin
      shift_d    = '0;
      byte_cnt_d = '0;
    end else if (i_byte_valid) begin
      shift_d    = o_word[23:0];
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a UART byte stream into instruction BRAM, one word per address
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                   ADDRESS_BITS = ADDRESS_BITS_DEFAULT,
  parameter int                   DATA_BITS    = DATA_BITS_DEFAULT,
  parameter logic [DATA_BITS-1:0] HALT_WORD    = HALT_WORD_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_write_enable,
  output logic [ADDRESS_BITS-1:0] o_address,
  output logic [DATA_BITS-1:0]    o_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic [ADDRESS_BITS:0]   o_word_count
);

  localparam logic [ADDRESS_BITS-1:0] ADDR_LAST = '1;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0]    data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [ADDRESS_BITS:0]   count_q, count_d;

  logic        start_ok;
  logic        packer_valid;
  logic [31:0] word;
  logic        word_valid;

  assign start_ok     = i_start && (state_q inside {IDLE, DONE, ERROR});
  // Bytes outside RECV (including the single WRITE cycle) never reach the packer.
  assign packer_valid = i_rx_valid && (state_q == RECV);

  program_loader_byte_packer u_byte_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (start_ok),
    .i_byte       (i_rx_data),
    .i_byte_valid (packer_valid),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_ok) begin
          state_d = RECV;
          addr_d  = '0;
          count_d = '0;
        end
      end
      RECV: begin
        if (word_valid) begin
          state_d = WRITE;
          we_d    = 1'b1;
          data_d  = word;
        end
      end
      WRITE: begin
        count_d = count_q + 1'b1;
        // The halt word wins even when it lands in the last address.
        if (data_q == HALT_WORD) begin
          state_d = DONE;
        end else if (addr_q == ADDR_LAST) begin
          state_d = ERROR;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = state_d inside {RECV, WRITE};
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      count_q <= count_d;
    end
  end

  assign o_write_enable = we_q;
  assign o_address      = addr_q;
  assign o_data         = data_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_word_count   = count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader, deep (256) and shallow (4) instances
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_rx_valid = 1'b0;
  logic [7:0] i_rx_data = 8'h00;

  logic        we_a, busy_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] data_a;
  logic [8:0]  cnt_a;
  logic        we_b, busy_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic [2:0]  cnt_b;

  program_loader #(.ADDRESS_BITS(8)) dut_a (
    .clk(clk), .rst(rst), .i_start(i_start), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_write_enable(we_a), .o_address(addr_a), .o_data(data_a), .o_busy(busy_a),
    .o_done(done_a), .o_error(err_a), .o_word_count(cnt_a)
  );

  program_loader #(.ADDRESS_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .i_start(i_start), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_write_enable(we_b), .o_address(addr_b), .o_data(data_b), .o_busy(busy_b),
    .o_done(done_b), .o_error(err_b), .o_word_count(cnt_b)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int          depth[2] = '{256, 4};
  bit          m_active[2];
  bit          m_busy[2];
  bit          m_done[2];
  bit          m_error[2];
  int          m_addr[2];
  int          m_count[2];
  int          m_nbytes[2];
  logic [31:0] m_word[2];
  bit          prev_we[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset(input int idx);
    m_active[idx] = 0; m_busy[idx] = 0; m_done[idx] = 0; m_error[idx] = 0;
    m_addr[idx] = 0; m_count[idx] = 0; m_nbytes[idx] = 0; m_word[idx] = 0;
  endtask

  // One clock of stimulus applied to the reference loader for instance idx.
  task automatic model_step(input int idx, input bit s, input bit v, input logic [7:0] d);
    exp_t e;
    bit   writing;
    writing = m_busy[idx];
    m_busy[idx] = 0;
    if (s && !m_active[idx] && !writing) begin
      m_active[idx] = 1; m_done[idx] = 0; m_error[idx] = 0;
      m_addr[idx] = 0; m_count[idx] = 0; m_nbytes[idx] = 0;
    end else if (v && m_active[idx] && !writing) begin
      m_word[idx] = (m_word[idx] << 8) | 32'(d);
      m_nbytes[idx]++;
      if (m_nbytes[idx] == 4) begin
        m_nbytes[idx] = 0;
        e.addr = m_addr[idx]; e.data = m_word[idx]; e.cyc = cyc + 1;
        if (idx == 0) exp_a.push_back(e);
        else exp_b.push_back(e);
        m_count[idx]++;
        m_busy[idx] = 1;
        if (m_word[idx] == 32'hFFFF_FFFF) begin
          m_done[idx] = 1; m_active[idx] = 0;
        end else if (m_addr[idx] == depth[idx] - 1) begin
          m_error[idx] = 1; m_active[idx] = 0;
        end else begin
          m_addr[idx]++;
        end
      end
    end
  endtask

  task automatic step(input bit s, input bit v, input logic [7:0] d);
    i_start = s; i_rx_valid = v; i_rx_data = d;
    for (int k = 0; k < 2; k++) model_step(k, s, v, d);
    @(posedge clk); #1; cyc++;
    i_start = 0; i_rx_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] w);
    step(0, 1, w[31:24]);
    step(0, 1, w[23:16]);
    step(0, 1, w[15:8]);
    step(0, 1, w[7:0]);
    idle(1);
  endtask

  task automatic do_reset(input int n);
    rst = 1; i_start = 0; i_rx_valid = 0; i_rx_data = 0;
    for (int k = 0; k < 2; k++) model_reset(k);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; cyc++; end
    rst = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " a we"}, we_a, 0);     chk({tag, " a addr"}, addr_a, 0);
    chk({tag, " a data"}, data_a, 0); chk({tag, " a busy"}, busy_a, 0);
    chk({tag, " a done"}, done_a, 0); chk({tag, " a error"}, err_a, 0);
    chk({tag, " a count"}, cnt_a, 0);
    chk({tag, " b we"}, we_b, 0);     chk({tag, " b addr"}, addr_b, 0);
    chk({tag, " b data"}, data_b, 0); chk({tag, " b busy"}, busy_b, 0);
    chk({tag, " b done"}, done_b, 0); chk({tag, " b error"}, err_b, 0);
    chk({tag, " b count"}, cnt_b, 0);
  endtask

  task automatic check_status(input string tag);
    chk({tag, " a done"}, done_a, m_done[0]);  chk({tag, " a error"}, err_a, m_error[0]);
    chk({tag, " a count"}, cnt_a, m_count[0]); chk({tag, " a addr"}, addr_a, m_addr[0]);
    chk({tag, " a busy"}, busy_a, m_active[0]);
    chk({tag, " b done"}, done_b, m_done[1]);  chk({tag, " b error"}, err_b, m_error[1]);
    chk({tag, " b count"}, cnt_b, m_count[1]); chk({tag, " b addr"}, addr_b, m_addr[1]);
    chk({tag, " b busy"}, busy_b, m_active[1]);
  endtask

  task automatic mon(input int idx, input logic we, input int addr, input logic [31:0] data);
    exp_t e;
    bit   empty;
    if (we) begin
      chk($sformatf("dut%0d back-to-back we", idx), prev_we[idx], 1'b0);
      empty = (idx == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0);
      if (empty) begin
        n_checks++;
        $display("FAIL dut%0d unexpected write: addr %0d data 0x%h, expected no write", idx, addr, data);
      end else begin
        e = (idx == 0) ? exp_a.pop_front() : exp_b.pop_front();
        chk($sformatf("dut%0d write addr", idx), addr, e.addr);
        chk($sformatf("dut%0d write data", idx), data, e.data);
        chk($sformatf("dut%0d write cycle", idx), cyc, e.cyc);
      end
    end
    prev_we[idx] = we;
  endtask

  always @(negedge clk) begin
    mon(0, we_a, int'(addr_a), data_a);
    mon(1, we_b, int'(addr_b), data_b);
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    do_reset(2);
    check_zero("reset");

    // Reset while two bytes of a word are pending.
    step(1, 0, 8'h00);
    step(0, 1, 8'hAA);
    step(0, 1, 8'hBB);
    do_reset(2);
    check_zero("midrst");
    step(1, 0, 8'h00);
    send_word(32'h11223344);
    idle(2);
    check_status("midrst load");

    do_reset(1);
    step(1, 0, 8'h00);
    send_word(32'h20010005);
    send_word(32'h00000000);
    send_word(32'hFFFFFFFF);
    idle(2);
    check_status("basic");
    chk("basic done", done_a, 1);
    chk("basic count", cnt_a, 3);
    chk("basic addr", addr_a, 2);

    // A byte strobed in the WRITE cycle must be dropped.
    do_reset(1);
    step(1, 0, 8'h00);
    step(0, 1, 8'hA1); step(0, 1, 8'hA2); step(0, 1, 8'hA3); step(0, 1, 8'hA4);
    step(0, 1, 8'h55);
    send_word(32'hB1B2B3B4);
    idle(2);
    check_status("timing");

    do_reset(1);
    step(1, 0, 8'h00);
    for (int i = 0; i < 4; i++) send_word(32'h01020304 + 32'(i) * 32'h10101010);
    idle(2);
    check_status("overflow");
    chk("overflow b error", err_b, 1);
    chk("overflow b done", done_b, 0);
    chk("overflow b count", cnt_b, 4);
    chk("overflow b addr", addr_b, 3);

    do_reset(1);
    step(1, 0, 8'h00);
    for (int i = 0; i < 3; i++) send_word(32'hCAFE0000 + 32'(i));
    send_word(32'hFFFFFFFF);
    idle(2);
    check_status("last halt");
    chk("last halt b done", done_b, 1);
    chk("last halt b error", err_b, 0);

    for (int i = 0; i < 8; i++) step(0, 1, 8'($urandom));
    idle(2);
    check_status("stray");
    step(1, 0, 8'h00);
    step(0, 1, 8'h12);
    step(1, 0, 8'h00);
    step(0, 1, 8'h34);
    step(1, 1, 8'h56);
    step(0, 1, 8'h78);
    idle(2);
    check_status("restart");
    chk("restart a count", cnt_a, 1);
    chk("restart a done", done_a, 0);

    // Random traffic; FF-heavy bytes so halt words occur regularly.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0,
           ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom));
      if (i % 300 == 299) begin
        idle(2);
        check_status($sformatf("random %0d", i));
      end
    end
    idle(3);
    chk("a pending writes", exp_a.size(), 0);
    chk("b pending writes", exp_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
